sm_input_filter: RTL and testbench
==================================

// Module: sm_input_filter
// PURPOSE
//  Multi-channel input conditioner for asynchronous board inputs (buttons, switches, GPIO in).
//  Each channel is resynchronised through a SYNC_STAGES flop chain, then debounced:
//  the output follows only after the input has held a new level for STABLE_CYCLES clocks.
//  Also emits single-cycle rise/fall pulses. Sits between top-level pins and the
//  CPU/peripheral logic, in the clk domain.
// PARAMETERS
//  WIDTH          1     number of independent channels
//  SYNC_STAGES    2     synchroniser depth per channel; must be >= 2
//  STABLE_CYCLES  4     consecutive cycles a new level must persist; must be >= 1 (1 = no filtering)
//  RESET_VALUE    0     WIDTH-bit reset level for the sync chain and q (per-bit)
// PORTS
//  clk    in   1      system clock
//  rst_n  in   1      asynchronous reset, active low
//  d      in   WIDTH  raw asynchronous inputs
//  q      out  WIDTH  synchronised, debounced level
//  rise   out  WIDTH  1-cycle pulse: q went 0->1 on this cycle's edge
//  fall   out  WIDTH  1-cycle pulse: q went 1->0 on this cycle's edge
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous, active-low (rst_n); all flops clear on negedge rst_n.
//  - Reset: sync chain = RESET_VALUE, q = RESET_VALUE, counters = 0, rise = fall = 0.
//  - Channels are fully independent; no cross-channel interaction.
//  - Sync: s[0] <= d; s[i] <= s[i-1]; s_out = s[SYNC_STAGES-1].
//  - Filter per channel, counter cnt of width clog2(STABLE_CYCLES) (min 1 bit):
//      s_out == q                          : cnt <= 0
//      s_out != q, cnt <  STABLE_CYCLES-1  : cnt <= cnt+1
//      s_out != q, cnt == STABLE_CYCLES-1  : q <= s_out, cnt <= 0, rise/fall <= edge
//  - rise/fall are registered, asserted exactly in the cycle q holds its new value; 0 otherwise.
//    rise and fall are never both high on one channel.
//  - Latency: d stable from before edge 1 -> q updates on edge SYNC_STAGES+STABLE_CYCLES.
//  - Glitch rejection: any excursion seen at s_out for < STABLE_CYCLES cycles leaves q unchanged
//    and produces no pulse; returning to q level mid-count clears cnt (no partial credit).
//  - Counter never wraps: max value STABLE_CYCLES-1, then it reloads 0.
//  - STABLE_CYCLES=1: q follows s_out with one cycle of delay; cnt is constant 0.
//  - Reset mid-count or mid-pulse: all state clears immediately; no pulse generated on
//    reset release even if d != RESET_VALUE; that difference is then filtered normally.
//  - Invalid parameters (SYNC_STAGES<2, STABLE_CYCLES<1) fail elaboration.
// STRUCTURE
//  - Sub-module sm_input_filter_ch: one channel (sync chain + counter + edge regs),
//    instantiated WIDTH times in a generate loop; top is wiring only.
//  - Shared include: clog2 helper function (min result 1); no other shared constants.
//  - Sync flops carry the synthesis attribute that marks them as async synchroniser registers.
// TESTING (SYNC_STAGES=2, STABLE_CYCLES=4, WIDTH=2, RESET_VALUE=0 unless stated)
//  1 Reset: hold rst_n=0, d=2'b11 -> q=0, rise=fall=0; release -> q[1:0]=11 on 6th edge, rise=11 that cycle only.
//  2 Latency: d[0] 0->1 before edge N -> q[0]=1 after edge N+5, rise[0]=1 for exactly 1 cycle, q[1] unchanged.
//  3 Glitch: d[0] high for 3 cycles then low -> q[0] stays 0, no pulses; 4 cycles -> q[0]=1, rise.
//  4 Bounce: d[0] toggles 1,0,1,1,1,1 -> count restarts at each return; q[0]=1 only after 4 stable 1s.
//  5 Async reset mid-count: d=1, assert rst_n low between edges at cnt=2 -> q,cnt,rise clear at once.
//  6 STABLE_CYCLES=1, RESET_VALUE=2'b10: after reset q=10; d=01 -> q=01 after 3rd edge, rise[0]=fall[1]=1.

Source files
------------

// File: rtl/sm_input_filter_pkg.sv
// Shared helpers for the input filter.
// Counter sizing used by every channel.
package sm_input_filter_pkg;

  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sm_input_filter_if.sv
// Pin-side bundle of the input filter.
// The master drives raw levels; the filter returns conditioned ones.
interface sm_input_filter_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  modport master (
    output d,
    input  q,
    input  rise,
    input  fall
  );

  modport slave (
    input  d,
    output q,
    output rise,
    output fall
  );
endinterface

// File: rtl/sm_input_filter_ch.sv
// One input channel: resynchroniser, debounce counter, edge pulses.
// q moves only after s_out has differed from it for STABLE_CYCLES clocks.
module sm_input_filter_ch
  import sm_input_filter_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 4,
  parameter logic RESET_BIT     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int CW = clog2_min1(STABLE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("STABLE_CYCLES must be >= 1");
  end

  (* ASYNC_REG = "TRUE" *)
  logic [SYNC_STAGES-1:0] s;
  logic [CW-1:0]          cnt;
  logic                   s_out;

  assign s_out = s[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= {SYNC_STAGES{RESET_BIT}};
    end else begin
      s <= {s[SYNC_STAGES-2:0], d};
    end
  end

  // cnt saturates at CMAX and reloads 0 when q takes the new level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= RESET_BIT;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s_out == q) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        q    <= s_out;
        cnt  <= '0;
        rise <= s_out;
        fall <= ~s_out;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sm_input_filter.sv
// Multi-channel synchroniser and debouncer for board inputs.
// Channels are independent; this level only replicates and wires them.
module sm_input_filter
  import sm_input_filter_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter int               SYNC_STAGES   = 2,
  parameter int               STABLE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input logic              clk,
  input logic              rst_n,
  sm_input_filter_if.slave bus
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sm_input_filter_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .RESET_BIT    (RESET_VALUE[i])
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (bus.d[i]),
      .q    (bus.q[i]),
      .rise (bus.rise[i]),
      .fall (bus.fall[i])
    );
  end

endmodule

// File: tb/tb_sm_input_filter.sv
// Bench for sm_input_filter: two configurations against a run-length model.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_sm_input_filter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sm_input_filter_if #(.WIDTH(2)) bus_a ();
  sm_input_filter_if #(.WIDTH(2)) bus_b ();

  sm_input_filter #(
    .WIDTH(2), .SYNC_STAGES(2), .STABLE_CYCLES(4), .RESET_VALUE(2'b00)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  sm_input_filter #(
    .WIDTH(2), .SYNC_STAGES(2), .STABLE_CYCLES(1), .RESET_VALUE(2'b10)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  // Reference: channels 0,1 are dut_a, channels 2,3 are dut_b.
  // q adopts the synchronised level once it has differed for a full run.
  bit mq[4];
  bit mr[4];
  bit mf[4];
  bit dl0[4];
  bit dl1[4];
  int run[4];

  function automatic int stab(input int c);
    return (c < 2) ? 4 : 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) begin
        dl0[c] = (c == 3);
        dl1[c] = (c == 3);
        mq[c]  = (c == 3);
        mr[c]  = 1'b0;
        mf[c]  = 1'b0;
        run[c] = 0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        bit din;
        bit s;
        din = (c < 2) ? bus_a.d[c[0]] : bus_b.d[c[0]];
        s = dl1[c];
        dl1[c] = dl0[c];
        dl0[c] = din;
        mr[c] = 1'b0;
        mf[c] = 1'b0;
        if (s != mq[c]) begin
          run[c]++;
          if (run[c] >= stab(c)) begin
            mq[c]  = s;
            mr[c]  = s;
            mf[c]  = !s;
            run[c] = 0;
          end
        end else begin
          run[c] = 0;
        end
      end
    end
  end

  logic [5:0] exp_a, exp_b, act_a, act_b;
  assign exp_a = {mq[1], mq[0], mr[1], mr[0], mf[1], mf[0]};
  assign exp_b = {mq[3], mq[2], mr[3], mr[2], mf[3], mf[2]};
  assign act_a = {bus_a.q, bus_a.rise, bus_a.fall};
  assign act_b = {bus_b.q, bus_b.rise, bus_b.fall};

  task automatic test_reset();
    rst_n = 1'b0;
    bus_a.d = 2'b11;
    bus_b.d = 2'b10;
    repeat (3) @(negedge clk);
    n_checks++;
    if (act_a !== 6'b00_00_00) begin
      n_fail++;
      $display("FAIL reset_a: q/rise/fall=%b expected 000000", act_a);
    end
    n_checks++;
    if (act_b !== 6'b10_00_00) begin
      n_fail++;
      $display("FAIL reset_b: q/rise/fall=%b expected 100000", act_b);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      logic [5:0] e;
      @(negedge clk);
      e = {(k >= 6) ? 2'b11 : 2'b00, (k == 6) ? 2'b11 : 2'b00, 2'b00};
      n_checks++;
      if (act_a !== e || act_a !== exp_a) begin
        n_fail++;
        $display("FAIL reset_release edge%0d: got %b expected %b model %b",
                 k, act_a, e, exp_a);
      end
    end
  endtask

  task automatic test_latency();
    bus_a.d = 2'b10;
    repeat (12) @(negedge clk);
    n_checks++;
    if (bus_a.q !== 2'b10) begin
      n_fail++;
      $display("FAIL latency_setup: q=%b expected 10", bus_a.q);
    end
    bus_a.d = 2'b11;
    for (int k = 1; k <= 7; k++) begin
      logic [5:0] e;
      @(negedge clk);
      e = {1'b1, k >= 6, 1'b0, k == 6, 2'b00};
      n_checks++;
      if (act_a !== e || act_a !== exp_a) begin
        n_fail++;
        $display("FAIL latency edge%0d: got %b expected %b model %b",
                 k, act_a, e, exp_a);
      end
    end
  endtask

  task automatic test_glitch();
    int rises;
    int falls;
    bus_a.d = 2'b00;
    repeat (12) @(negedge clk);
    bus_a.d = 2'b01;
    for (int k = 0; k < 15; k++) begin
      if (k == 3) bus_a.d = 2'b00;
      @(negedge clk);
      n_checks++;
      if (act_a !== 6'b0 || act_a !== exp_a) begin
        n_fail++;
        $display("FAIL glitch3 cyc%0d: got %b expected 000000", k, act_a);
      end
    end
    rises = 0;
    falls = 0;
    bus_a.d = 2'b01;
    for (int k = 0; k < 16; k++) begin
      if (k == 4) bus_a.d = 2'b00;
      @(negedge clk);
      rises += int'(bus_a.rise[0]);
      falls += int'(bus_a.fall[0]);
      n_checks++;
      if (act_a !== exp_a) begin
        n_fail++;
        $display("FAIL glitch4 cyc%0d: got %b model %b", k, act_a, exp_a);
      end
    end
    n_checks++;
    if (rises != 1 || falls != 1) begin
      n_fail++;
      $display("FAIL glitch4_pulses: rise=%0d fall=%0d expected 1 1",
               rises, falls);
    end
  endtask

  task automatic test_bounce();
    bit seq[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int first_hi;
    int rises;
    bus_a.d = 2'b00;
    repeat (12) @(negedge clk);
    first_hi = -1;
    rises = 0;
    for (int k = 1; k <= 14; k++) begin
      bus_a.d = {1'b0, (k <= 6) ? seq[k-1] : 1'b1};
      @(negedge clk);
      if (bus_a.q[0] && first_hi < 0) first_hi = k;
      rises += int'(bus_a.rise[0]);
      n_checks++;
      if (act_a !== exp_a) begin
        n_fail++;
        $display("FAIL bounce edge%0d: got %b model %b", k, act_a, exp_a);
      end
    end
    n_checks++;
    if (first_hi != 8 || rises != 1) begin
      n_fail++;
      $display("FAIL bounce_timing: q0 high at edge %0d rises %0d, expected 8 1",
               first_hi, rises);
    end
  endtask

  task automatic test_async_reset();
    bus_a.d = 2'b11;
    repeat (12) @(negedge clk);
    bus_a.d = 2'b00;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (act_a !== 6'b0 || act_a !== exp_a) begin
      n_fail++;
      $display("FAIL async_clear: got %b expected 000000", act_a);
    end
    bus_a.d = 2'b11;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      logic [5:0] e;
      @(negedge clk);
      e = {(k >= 6) ? 2'b11 : 2'b00, (k == 6) ? 2'b11 : 2'b00, 2'b00};
      n_checks++;
      if (act_a !== e || act_a !== exp_a) begin
        n_fail++;
        $display("FAIL async_release edge%0d: got %b expected %b", k, act_a, e);
      end
    end
  endtask

  task automatic test_stable1();
    rst_n = 1'b0;
    bus_a.d = 2'b00;
    bus_b.d = 2'b10;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (act_b !== 6'b10_00_00) begin
      n_fail++;
      $display("FAIL stable1_reset: got %b expected 100000", act_b);
    end
    bus_b.d = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      logic [5:0] e;
      @(negedge clk);
      e = (k == 3) ? 6'b01_01_10 : (k > 3) ? 6'b01_00_00 : 6'b10_00_00;
      n_checks++;
      if (act_b !== e || act_b !== exp_b) begin
        n_fail++;
        $display("FAIL stable1 edge%0d: got %b expected %b", k, act_b, e);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 9) < 3) bus_a.d = 2'($urandom);
      if ($urandom_range(0, 9) < 4) bus_b.d = 2'($urandom);
      @(negedge clk);
      n_checks++;
      if (act_a !== exp_a || act_b !== exp_b) begin
        n_fail++;
        $display("FAIL random cyc%0d: a=%b/%b b=%b/%b (got/model)",
                 k, act_a, exp_a, act_b, exp_b);
      end
    end
  endtask

  initial begin
    bus_a.d = 2'b00;
    bus_b.d = 2'b10;
    test_reset();
    test_latency();
    test_glitch();
    test_bounce();
    test_async_reset();
    test_stable1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
